// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, branch flush and hazard bubble.
// Define PIPELINE_STALL_CTRL_STATS_EN to build the hazard/memory-stall/flush statistics counters.
module pipeline_stall_ctrl #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazardIn,
    input  logic             branchTakenIn,
    input  logic             memReqIn,
    input  logic             memReadyIn,
    output logic             pcFreezeOut,
    output logic             ifIdFreezeOut,
    output logic             ifIdFlushOut,
    output logic             idExeFlushOut,
    output logic             backFreezeOut,
    output logic             memTimeoutOut,
    output logic [CNT_W-1:0] hazardCntOut,
    output logic [CNT_W-1:0] memStallCntOut,
    output logic [CNT_W-1:0] flushCntOut,
    output logic [1:0]       stateDbgOut
);

    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           mem_stall;
    logic           branch_apply;
    logic           hazard_apply;

    assign mem_stall     = memReqIn & ~memReadyIn;
    assign memTimeoutOut = (state_q == TIMEOUT);
    assign stateDbgOut   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        pcFreezeOut   = 1'b0;
        ifIdFreezeOut = 1'b0;
        ifIdFlushOut  = 1'b0;
        idExeFlushOut = 1'b0;
        backFreezeOut = 1'b0;
        branch_apply  = 1'b0;
        hazard_apply  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = WCW'(1);
                end
            end
            MEM_WAIT: begin
                // A dropped request is an aborted access, treated like completion.
                if (memReadyIn || !memReqIn) begin
                    state_d = IDLE;
                    wait_d  = '0;
                end else if (wait_q == WCW'(WAIT_LIMIT)) begin
                    state_d = TIMEOUT;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            TIMEOUT: state_d = TIMEOUT;
            default: begin
                state_d = IDLE;
                wait_d  = '0;
            end
        endcase

        if (rst) begin
            pcFreezeOut = 1'b0;
        end else if (state_q == TIMEOUT || mem_stall) begin
            pcFreezeOut   = 1'b1;
            ifIdFreezeOut = 1'b1;
            backFreezeOut = 1'b1;
        end else if (branchTakenIn) begin
            ifIdFlushOut  = 1'b1;
            idExeFlushOut = 1'b1;
            branch_apply  = 1'b1;
        end else if (hazardIn) begin
            pcFreezeOut   = 1'b1;
            ifIdFreezeOut = 1'b1;
            idExeFlushOut = 1'b1;
            hazard_apply  = 1'b1;
        end
    end

`ifdef PIPELINE_STALL_CTRL_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] hazard_cnt_q, mem_cnt_q, flush_cnt_q;

    // Counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clk) begin
        if (rst) begin
            hazard_cnt_q <= '0;
            mem_cnt_q    <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (hazard_apply && hazard_cnt_q != CNT_MAX) hazard_cnt_q <= hazard_cnt_q + CNT_W'(1);
            if (backFreezeOut && mem_cnt_q != CNT_MAX) mem_cnt_q <= mem_cnt_q + CNT_W'(1);
            if (branch_apply && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hazardCntOut   = hazard_cnt_q;
    assign memStallCntOut = mem_cnt_q;
    assign flushCntOut    = flush_cnt_q;
`else
    logic unused_apply;
    assign unused_apply   = hazard_apply ^ branch_apply;
    assign hazardCntOut   = '0;
    assign memStallCntOut = '0;
    assign flushCntOut    = '0;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, maximum consecutive memory-wait cycles before timeout (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port hazardIn  input  1  data hazard from the hazard detection unit.
REQ-006 SHALL have port branchTakenIn  input  1  taken branch resolved in EXE.
REQ-007 SHALL have port memReqIn  input  1  MEM stage holds a load or store.
REQ-008 SHALL have port memReadyIn  input  1  data memory completes the access this cycle.
REQ-009 SHALL have port pcFreezeOut  output  1  hold PC.
REQ-010 SHALL have port ifIdFreezeOut  output  1  hold IF/ID register.
REQ-011 SHALL have port ifIdFlushOut  output  1  clear IF/ID to NOP.
REQ-012 SHALL have port idExeFlushOut  output  1  clear ID/EXE to bubble.
REQ-013 SHALL have port backFreezeOut  output  1  hold ID/EXE, EXE/MEM, MEM/WB.
REQ-014 SHALL have port memTimeoutOut  output  1  sticky memory timeout flag.
REQ-015 SHALL have ports hazardCntOut, memStallCntOut, flushCntOut  output  CNT_W each  statistics counters.

Function
REQ-016 SHALL implement FSM states IDLE, MEM_WAIT, TIMEOUT, plus a wait counter of ceil(log2(WAIT_LIMIT+1)) bits.
REQ-017 SHALL define memStall = memReqIn & ~memReadyIn (combinational).
REQ-018 IDLE: memStall -> MEM_WAIT with wait counter = 1; else remain IDLE.
REQ-019 MEM_WAIT: memReadyIn -> IDLE, wait counter cleared; else if wait counter == WAIT_LIMIT -> TIMEOUT; else increment wait counter.
REQ-020 MEM_WAIT with memReqIn deasserted SHALL return to IDLE (aborted access).
REQ-021 TIMEOUT: SHALL remain until rst; memTimeoutOut = 1; all five freeze/flush outputs: freezes = 1, flushes = 0.
REQ-022 Memory stall (memStall=1 in IDLE or MEM_WAIT) SHALL assert pcFreezeOut, ifIdFreezeOut, backFreezeOut and deassert both flushes; highest priority.
REQ-023 Cycle memReadyIn=1 SHALL release all freezes that same cycle (zero-cycle release latency).
REQ-024 Branch (branchTakenIn=1, no memory stall) SHALL assert ifIdFlushOut and idExeFlushOut, no freezes; overrides hazardIn.
REQ-025 Branch during memory stall SHALL be ignored that cycle; the branch stays in EXE and flushes on the release cycle.
REQ-026 Hazard (hazardIn=1, no branch, no memory stall) SHALL assert pcFreezeOut, ifIdFreezeOut, idExeFlushOut only.
REQ-027 No condition SHALL drive all outputs 0; freeze/flush outputs are combinational from state and inputs.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE, wait counter 0, memTimeoutOut 0, all statistics counters 0.
REQ-029 While rst=1 all freeze/flush outputs SHALL be 0 regardless of inputs.
REQ-030 rst during MEM_WAIT or TIMEOUT SHALL return to IDLE on the next edge; pending branch/hazard are not remembered.

Configuration
REQ-031 Macro PIPELINE_STALL_CTRL_STATS_EN SHALL compile in the statistics counters.
REQ-032 With the macro: hazardCntOut +1 per cycle REQ-026 applies, memStallCntOut +1 per cycle backFreezeOut=1, flushCntOut +1 per cycle REQ-024 applies; each saturates at 2^CNT_W-1.
REQ-033 Without the macro: the three counter outputs SHALL be constant 0 and no counter registers synthesized; all other behaviour identical.

Verification
REQ-034 hazardIn=1 for 1 cycle, others 0 -> pcFreezeOut=ifIdFreezeOut=idExeFlushOut=1 that cycle, backFreezeOut=0; hazardCntOut=1 after edge.
REQ-035 branchTakenIn=1 with hazardIn=1 -> both flushes=1, no freezes; flushCntOut=1, hazardCntOut=0.
REQ-036 memReqIn=1, memReadyIn=0 for 3 cycles then 1 -> freezes 1 for 3 cycles, 0 on 4th; state IDLE after; memStallCntOut=3.
REQ-037 WAIT_LIMIT=4, memReadyIn held 0 -> TIMEOUT after 5th edge, memTimeoutOut=1 and freezes held; later memReadyIn=1 changes nothing; rst -> outputs 0, IDLE.
REQ-038 branchTakenIn=1 during memory stall -> no flush until memReadyIn=1 cycle, then both flushes=1 with freezes=0.
REQ-039 Build without PIPELINE_STALL_CTRL_STATS_EN, rerun REQ-034..REQ-036 -> identical control outputs, all counters 0.
